// File: rtl/ocm_frame_writer.sv
// ocm_frame_writer
// ----------------
// Captures one frame of 8-bit pixels from a valid-qualified stream and writes
// them to consecutive OCM0 word addresses through the FPGA-side slave port (s2).
// This is the write-side counterpart of the OCM0 image reader. frame_done is
// meant to drive that reader's start input.
//
// Optional feature: define OCM_FRAME_CHECKSUM_EN to add the 16-bit checksum
// output. It is the modulo-2^16 sum of every accepted pixel in the frame.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   start           single-cycle arm request (honoured only in IDLE)
//   in_data, in_dv  pixel stream; a beat is in_data qualified by in_dv
//   ocm0_*          OCM s2 port: addr, chipselect, clken, write, writedata
//   busy            high while ARMED or WRITE
//   frame_done      one-cycle pulse in the cycle after the last OCM write
//   overrun         sticky: a beat arrived while not armed
//   count           pixels written in the current or last frame (saturating)
//   checksum        (OCM_FRAME_CHECKSUM_EN only) pixel sum of the frame
//   dbg_state       current FSM state, for checkers and debug
//
// Handshake: there is no back-pressure. Every cycle with in_dv=1 in ARMED or
// WRITE is an accepted beat. Its write appears on the OCM port one cycle later.
// Beats in any other state are dropped.
module ocm_frame_writer #(
    parameter int ADDR_WIDTH   = 17,
    parameter int BASE_ADDR    = 0,
    parameter int FRAME_PIXELS = 784
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_data,
    input  logic                  in_dv,
    output logic [ADDR_WIDTH-1:0] ocm0_addr,
    output logic                  ocm0_chip,
    output logic                  ocm0_clk_enab,
    output logic                  ocm0_write,
    output logic [7:0]            ocm0_writedata,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic [15:0]           count,
`ifdef OCM_FRAME_CHECKSUM_EN
    output logic [15:0]           checksum,
`endif
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   index_q, index_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ovr_q, ovr_d;
    logic                    cen_q;
    logic [15:0]             count_q, count_d;
    logic [15:0]             csum_q, csum_d;
    logic                    accept;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = 1'b0;
        ovr_d   = ovr_q;
        count_d = count_q;
        csum_d  = csum_q;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A beat that arrives together with start is dropped.
                // It does not count as an overrun.
                if (start) begin
                    state_d = S_ARMED;
                    index_d = '0;
                    count_d = '0;
                    ovr_d   = 1'b0;
                    csum_d  = '0;
                end else if (in_dv) begin
                    ovr_d = 1'b1;
                end
            end
            S_ARMED, S_WRITE: begin
                if (in_dv) begin
                    accept = 1'b1;
                    // With FRAME_PIXELS=1 the first beat from ARMED is
                    // already the last one, so ARMED goes straight to DONE.
                    state_d = (index_q == LAST) ? S_DONE : S_WRITE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (in_dv) ovr_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            write_d = 1'b1;
            addr_d  = BASE + index_q;
            wdata_d = in_data;
            index_d = index_q + 1'b1;
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            csum_d  = csum_q + {8'h00, in_data};
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_WRITE);
        // DONE holds the final write, so the pulse lands in the cycle after it.
        done_d = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            addr_q  <= BASE;
            wdata_q <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cen_q   <= 1'b0;
            count_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            cen_q   <= 1'b1;
            count_q <= count_d;
            csum_q  <= csum_d;
        end
    end

    assign ocm0_addr      = addr_q;
    assign ocm0_chip      = write_q;
    assign ocm0_write     = write_q;
    assign ocm0_writedata = wdata_q;
    assign ocm0_clk_enab  = cen_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign overrun        = ovr_q;
    assign count          = count_q;
    assign dbg_state      = state_q;
`ifdef OCM_FRAME_CHECKSUM_EN
    assign checksum       = csum_q;
`else
    // The running sum is only observable when the checksum port exists.
    logic unused_csum;
    assign unused_csum = ^csum_q;
`endif

endmodule

// File: tb/tb_ocm_frame_writer.sv
// Testbench for ocm_frame_writer, configured with FRAME_PIXELS=16 and
// BASE_ADDR=0x100. A vector table covers the single-cycle behaviour. Tasks
// cover full frames, gapped input, ignored start, reset mid-frame and the
// checksum. An OCM write monitor checks every strobe against an expected
// queue.
module tb_ocm_frame_writer;

    localparam int AW = 17;
    localparam int NPIX = 16;
    localparam logic [AW-1:0] BASE = 17'h100;

    logic            clk;
    logic            reset;
    logic            start;
    logic [7:0]      in_data;
    logic            in_dv;
    logic [AW-1:0]   ocm0_addr;
    logic            ocm0_chip;
    logic            ocm0_clk_enab;
    logic            ocm0_write;
    logic [7:0]      ocm0_writedata;
    logic            busy;
    logic            frame_done;
    logic            overrun;
    logic [15:0]     count;
    logic [1:0]      dbg_state;
`ifdef OCM_FRAME_CHECKSUM_EN
    logic [15:0]     checksum;
`endif

    ocm_frame_writer #(
        .ADDR_WIDTH  (AW),
        .BASE_ADDR   (256),
        .FRAME_PIXELS(NPIX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .in_data       (in_data),
        .in_dv         (in_dv),
        .ocm0_addr     (ocm0_addr),
        .ocm0_chip     (ocm0_chip),
        .ocm0_clk_enab (ocm0_clk_enab),
        .ocm0_write    (ocm0_write),
        .ocm0_writedata(ocm0_writedata),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun),
        .count         (count),
`ifdef OCM_FRAME_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Scoreboard
    logic [AW+7:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // OCM write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ocm0_write || ocm0_chip) begin
                if (exp_q.size() == 0) begin
                    check("spurious_write", {31'd0, ocm0_write}, 32'd0);
                end else begin
                    logic [AW+7:0] e;
                    e = exp_q.pop_front();
                    check("ocm_write", {6'd0, ocm0_chip, ocm0_write, ocm0_addr, ocm0_writedata},
                          {6'd0, 1'b1, 1'b1, e});
                end
            end
            if (frame_done) done_cnt++;
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"},  {15'd0, ocm0_addr}, {15'd0, BASE});
        check({tag, "_write"}, {30'd0, ocm0_chip, ocm0_write}, 32'd0);
        check({tag, "_data"},  {24'd0, ocm0_writedata}, 32'd0);
        check({tag, "_flags"}, {29'd0, busy, frame_done, overrun}, 32'd0);
        check({tag, "_count"}, {16'd0, count}, 32'd0);
        check({tag, "_cen"},   {31'd0, ocm0_clk_enab}, 32'd0);
`ifdef OCM_FRAME_CHECKSUM_EN
        check({tag, "_csum"},  {16'd0, checksum}, 32'd0);
`endif
    endtask

    // Runs one frame: a start pulse, then NPIX beats with `gap` idle cycles
    // between them. A second start is injected before beat `restart_at`.
    task automatic run_frame(input int gap, input int restart_at,
                             input logic [7:0] d0, input logic [7:0] dstep,
                             input logic [15:0] exp_sum);
        logic [7:0]  d;
        logic [15:0] sum;
        int          waited;
        start = 1'b1;
        step();
        start = 1'b0;
        check("armed_busy", {31'd0, busy}, 32'd1);
        check("armed_overrun_clear", {31'd0, overrun}, 32'd0);
        sum = '0;
        for (int i = 0; i < NPIX; i++) begin
            if (i == restart_at) begin
                start = 1'b1;
                step();
                start = 1'b0;
                check("restart_ignored_busy", {31'd0, busy}, 32'd1);
            end
            d = d0 + 8'(i) * dstep;
            exp_q.push_back({BASE + AW'(i), d});
            sum = sum + {8'h00, d};
            in_dv = 1'b1;
            in_data = d;
            step();
            in_dv = 1'b0;
            if (i < NPIX - 1) repeat (gap) step();
        end
        // The last write is on the port now; frame_done must follow next cycle.
        waited = 0;
        while (!frame_done && waited < 20) begin
            step();
            waited++;
        end
        exp_done++;
        check("done_latency", waited, 1);
        check("done_count", {16'd0, count}, NPIX);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("queue_drained", exp_q.size(), 0);
        check("model_sum", {16'd0, sum}, {16'd0, exp_sum});
`ifdef OCM_FRAME_CHECKSUM_EN
        check("checksum", {16'd0, checksum}, {16'd0, exp_sum});
`endif
        step();
        check("done_pulse_width", {31'd0, frame_done}, 32'd0);
        check("count_hold", {16'd0, count}, NPIX);
    endtask

    // Single-cycle vector table: inputs for one cycle, expected outputs after the edge.
    typedef struct {
        logic        start;
        logic        dv;
        logic [7:0]  din;
        logic        exp_wr;
        logic [AW-1:0] exp_addr;
        logic [7:0]  exp_data;
        logic        exp_busy;
        logic        exp_ovr;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Rows: beat in IDLE (overrun, dropped), start+dv (arm and drop, overrun cleared),
        // writes with a gap, and a start mid-frame that must be ignored.
        vecs[0] = '{1'b0, 1'b1, 8'hAA, 1'b0, 17'h100, 8'h00, 1'b0, 1'b1, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 8'h55, 1'b0, 17'h100, 8'h00, 1'b1, 1'b0, 16'd0};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b1, 17'h100, 8'h00, 1'b1, 1'b0, 16'd1};
        vecs[3] = '{1'b0, 1'b0, 8'h77, 1'b0, 17'h100, 8'h00, 1'b1, 1'b0, 16'd1};
        vecs[4] = '{1'b0, 1'b1, 8'h01, 1'b1, 17'h101, 8'h01, 1'b1, 1'b0, 16'd2};
        vecs[5] = '{1'b1, 1'b1, 8'h02, 1'b1, 17'h102, 8'h02, 1'b1, 1'b0, 16'd3};
        vecs[6] = '{1'b0, 1'b1, 8'h03, 1'b1, 17'h103, 8'h03, 1'b1, 1'b0, 16'd4};

        reset = 1'b1;
        start = 1'b0;
        in_dv = 1'b0;
        in_data = 8'h00;
        repeat (3) step();
        check_reset_vals("reset");
        reset = 1'b0;
        step();
        check("clk_enab_after_reset", {31'd0, ocm0_clk_enab}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            start = vecs[i].start;
            in_dv = vecs[i].dv;
            in_data = vecs[i].din;
            step();
            check($sformatf("vec%0d_write", i), {30'd0, ocm0_chip, ocm0_write},
                  {30'd0, vecs[i].exp_wr, vecs[i].exp_wr});
            check($sformatf("vec%0d_addr", i), {15'd0, ocm0_addr}, {15'd0, vecs[i].exp_addr});
            check($sformatf("vec%0d_data", i), {24'd0, ocm0_writedata}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d_overrun", i), {31'd0, overrun}, {31'd0, vecs[i].exp_ovr});
            check($sformatf("vec%0d_count", i), {16'd0, count}, {16'd0, vecs[i].exp_cnt});
            check($sformatf("vec%0d_done", i), {31'd0, frame_done}, 32'd0);
        end
        start = 1'b0;
        in_dv = 1'b0;

        // Abandon the table's partial frame.
        reset = 1'b1;
        step();
        check_reset_vals("table_reset");
        reset = 1'b0;
        step();

        mon_en = 1'b1;
        run_frame(0, -1, 8'h00, 8'h01, 16'h0078);   // basic, data 0x00..0x0F
        run_frame(2, -1, 8'h10, 8'h01, 16'h0178);   // gapped 1,0,0,1,...
        run_frame(0, 5, 8'h20, 8'h01, 16'h0278);    // second start after 5 beats

        // Reset after 7 writes: no frame_done, outputs back to reset values.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back({BASE + AW'(i), 8'h80 + 8'(i)});
            in_dv = 1'b1;
            in_data = 8'h80 + 8'(i);
            step();
        end
        in_dv = 1'b0;
        reset = 1'b1;
        step();
        check_reset_vals("midframe_reset");
        reset = 1'b0;
        repeat (4) step();
        check("midframe_no_done", done_cnt, exp_done);
        check("midframe_queue", exp_q.size(), 0);
        run_frame(0, -1, 8'h40, 8'h01, 16'h0478);   // restarts at 0x100

        run_frame(0, -1, 8'hFF, 8'h00, 16'h0FF0);   // 16 x 0xFF
        run_frame(0, -1, 8'h01, 8'h00, 16'h0010);   // 16 x 0x01

        repeat (3) step();
        check("total_frame_done", done_cnt, exp_done);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog: all waits above are bounded, this catches anything else.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
